// File: rtl/iter_alu.sv
// EX-stage ALU: decodes {funct7,funct3}/ALUOp and executes single-cycle ops,
// with an iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
module iter_alu #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [9:0]      funct_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            valid_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int SHW    = $clog2(XLEN);
  localparam int N_ITER = XLEN / MUL_BITS;
  localparam int CW     = $clog2(N_ITER + 1);

  // Handshake: an operation is accepted on a rising edge where valid_i && ready_o;
  // valid_o is a one-cycle pulse, and result_o/zero_o/illegal_o hold until the next completion.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_MUL, OP_ILL
  } op_t;

  state_t state_q, state_d;
  op_t    op;

  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            accept;

  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pp, acc_sum;

  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  assign funct7 = funct_i[9:3];
  assign funct3 = funct_i[2:0];
  assign shamt  = src2_i[SHW-1:0];
  assign accept = valid_i && ready_o;

  always_comb begin
    op = OP_ILL;
    case (ALUOp_i)
      2'b00: begin
        case (funct3)
          3'b000: begin
            if (funct7 == 7'h00)      op = OP_ADD;
            else if (funct7 == 7'h20) op = OP_SUB;
            else if (funct7 == 7'h01) op = OP_MUL;
          end
          3'b101: begin
            if (funct7 == 7'h00)      op = OP_SRL;
            else if (funct7 == 7'h20) op = OP_SRA;
          end
          default: begin
            if (funct7 == 7'h00) begin
              case (funct3)
                3'b111:  op = OP_AND;
                3'b110:  op = OP_OR;
                3'b100:  op = OP_XOR;
                3'b001:  op = OP_SLL;
                3'b010:  op = OP_SLT;
                3'b011:  op = OP_SLTU;
                default: op = OP_ILL;
              endcase
            end
          end
        endcase
      end
      2'b01: begin
        // I-type funct7 bits are immediate bits, so only the shifts constrain them
        case (funct3)
          3'b000: op = OP_ADD;
          3'b111: op = OP_AND;
          3'b110: op = OP_OR;
          3'b100: op = OP_XOR;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b001: if (funct7 == 7'h00) op = OP_SLL;
          3'b101: begin
            if (funct7 == 7'h00)      op = OP_SRL;
            else if (funct7 == 7'h20) op = OP_SRA;
          end
          default: op = OP_ILL;
        endcase
      end
      2'b10:   op = OP_ADD;
      default: op = OP_SUB;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_XOR:  alu_res = src1_i ^ src2_i;
      OP_SLL:  alu_res = src1_i << shamt;
      OP_SRL:  alu_res = src1_i >> shamt;
      OP_SRA:  alu_res = $signed(src1_i) >>> shamt;
      OP_SLT:  alu_res = XLEN'($signed(src1_i) < $signed(src2_i));
      OP_SLTU: alu_res = XLEN'(src1_i < src2_i);
      default: alu_res = '0;
    endcase
  end

  // mcand_q is pre-shifted to the current bit position, so the partial product is local
  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (mplier_q[j]) pp = pp + (mcand_q << j);
    end
    acc_sum = acc_q + pp;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MUL: if (cnt_q == CW'(1)) state_d = S_DONE;
      default: begin
        if (accept) state_d = (op == OP_MUL) ? S_MUL : S_DONE;
        else        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ready_o = (state_q != S_MUL);
    busy_o  = (state_q == S_MUL);
    valid_o = (state_q == S_DONE);
  end

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (state_q == S_MUL) begin
      mcand_d  = mcand_q << MUL_BITS;
      mplier_d = mplier_q >> MUL_BITS;
      acc_d    = acc_sum;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        result_d  = acc_sum;
        zero_d    = (acc_sum == '0);
        illegal_d = 1'b0;
      end
    end else if (accept) begin
      if (op == OP_MUL) begin
        mcand_d  = src1_i;
        mplier_d = src2_i;
        acc_d    = '0;
        cnt_d    = CW'(N_ITER);
      end else begin
        result_d  = (op == OP_ILL) ? '0 : alu_res;
        zero_d    = (op == OP_ILL) ? 1'b1 : (alu_res == '0);
        illegal_d = (op == OP_ILL);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: three instances (MUL_BITS 1, 4, 32) share one input stream.
module tb_iter_alu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [9:0]  funct = '0;
  logic [1:0]  aluop = '0;
  logic [31:0] src1 = '0, src2 = '0;

  logic        ready, busy, vld, zero, ill;
  logic [31:0] res;
  logic        ready4, busy4, vld4, zero4, ill4;
  logic [31:0] res4;
  logic        ready32, busy32, vld32, zero32, ill32;
  logic [31:0] res32;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iter_alu #(.XLEN(32), .MUL_BITS(1)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .funct_i(funct),
    .ALUOp_i(aluop), .src1_i(src1), .src2_i(src2), .result_o(res), .zero_o(zero),
    .valid_o(vld), .illegal_o(ill), .busy_o(busy));

  iter_alu #(.XLEN(32), .MUL_BITS(4)) dut_m4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready4), .funct_i(funct),
    .ALUOp_i(aluop), .src1_i(src1), .src2_i(src2), .result_o(res4), .zero_o(zero4),
    .valid_o(vld4), .illegal_o(ill4), .busy_o(busy4));

  iter_alu #(.XLEN(32), .MUL_BITS(32)) dut_m32 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready32), .funct_i(funct),
    .ALUOp_i(aluop), .src1_i(src1), .src2_i(src2), .result_o(res32), .zero_o(zero32),
    .valid_o(vld32), .illegal_o(ill32), .busy_o(busy32));

  // inputs change only on falling edges, outputs sampled there before driving
  task automatic drive(input logic [1:0] op, input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    valid = 1'b1; aluop = op; funct = f; src1 = a; src2 = b;
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b0; drive(2'b00, 10'h000, 32'd1, 32'd1);
    @(negedge clk); rst = 1'b1; drive(2'b00, 10'h008, 32'd9, 32'd9);
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (res !== 32'd0) begin n_err++; $display("FAIL reset_result got %h exp 0", res); end
    n_vec++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got %b exp 0", zero); end
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", vld); end
    n_vec++; if (ill !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b exp 0", ill); end
    n_vec++; if (ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL reset_ready got r=%b b=%b exp r=1 b=0", ready, busy); end
    n_vec++; if (ready4 !== 1'b1 || ready32 !== 1'b1) begin n_err++; $display("FAIL reset_ready_wide got %b %b exp 1 1", ready4, ready32); end
    rst = 1'b0; valid = 1'b0;
  endtask

  task automatic test_add;
    @(negedge clk);
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL add_pre_valid got %b exp 0", vld); end
    drive(2'b00, 10'h000, 32'd5, 32'd7);
    @(negedge clk);
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL add_valid got %b exp 1", vld); end
    n_vec++; if (res !== 32'd12 || zero !== 1'b0) begin n_err++; $display("FAIL add_result got %h z=%b exp 0000000c z=0", res, zero); end
    valid = 1'b0;
    @(negedge clk);
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL add_pulse got %b exp 0", vld); end
    n_vec++; if (res !== 32'd12) begin n_err++; $display("FAIL add_hold got %h exp 0000000c", res); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); drive(2'b00, 10'h100, 32'd3, 32'd3);
    @(negedge clk);
    n_vec++; if (vld !== 1'b1 || res !== 32'd0 || zero !== 1'b1) begin n_err++; $display("FAIL b2b_sub got v=%b %h z=%b exp v=1 00000000 z=1", vld, res, zero); end
    drive(2'b00, 10'h105, 32'h8000_0000, 32'd4);
    @(negedge clk);
    n_vec++; if (vld !== 1'b1 || res !== 32'hF800_0000 || zero !== 1'b0) begin n_err++; $display("FAIL b2b_sra got v=%b %h z=%b exp v=1 f8000000 z=0", vld, res, zero); end
    drive(2'b00, 10'h003, 32'd1, 32'hFFFF_FFFF);
    @(negedge clk);
    n_vec++; if (vld !== 1'b1 || res !== 32'd1 || zero !== 1'b0) begin n_err++; $display("FAIL b2b_sltu got v=%b %h z=%b exp v=1 00000001 z=0", vld, res, zero); end
    valid = 1'b0;
    @(negedge clk);
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b exp 0", vld); end
  endtask

  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int c1, c4, c32, pulses, busy_cnt, rdy_lo;
    logic [31:0] r1, r4, r32;
    logic z1;
    c1 = 0; c4 = 0; c32 = 0; pulses = 0; busy_cnt = 0; rdy_lo = 0;
    r1 = '0; r4 = '0; r32 = '0; z1 = 1'b0;
    @(negedge clk); drive(2'b00, 10'h008, a, b);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ready === 1'b0) rdy_lo++;
      if (busy === 1'b1) busy_cnt++;
      if (vld === 1'b1) begin pulses++; if (c1 == 0) begin c1 = c; r1 = res; z1 = zero; end end
      if (vld4 === 1'b1 && c4 == 0) begin c4 = c; r4 = res4; end
      if (vld32 === 1'b1 && c32 == 0) begin c32 = c; r32 = res32; end
      // junk request on the edge where every instance is still multiplying
      if (c == 1) drive(2'b00, 10'h000, 32'h1234, 32'h1);
      else valid = 1'b0;
    end
    n_vec++; if (c1 !== 33) begin n_err++; $display("FAIL mul1_latency got %0d exp 33", c1); end
    n_vec++; if (r1 !== exp || z1 !== (exp == 32'd0)) begin n_err++; $display("FAIL mul1_result got %h z=%b exp %h", r1, z1, exp); end
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL mul1_pulses got %0d exp 1", pulses); end
    n_vec++; if (rdy_lo !== 32 || busy_cnt !== 32) begin n_err++; $display("FAIL mul1_busy got rlo=%0d busy=%0d exp 32 32", rdy_lo, busy_cnt); end
    n_vec++; if (c4 !== 9 || r4 !== exp) begin n_err++; $display("FAIL mul4 got cyc=%0d %h exp cyc=9 %h", c4, r4, exp); end
    n_vec++; if (c32 !== 2 || r32 !== exp) begin n_err++; $display("FAIL mul32 got cyc=%0d %h exp cyc=2 %h", c32, r32, exp); end
  endtask

  task automatic test_illegal;
    @(negedge clk); drive(2'b00, 10'h009, 32'd5, 32'd6);
    @(negedge clk);
    n_vec++; if (vld !== 1'b1 || ill !== 1'b1 || res !== 32'd0 || zero !== 1'b1) begin n_err++; $display("FAIL ill_r got v=%b i=%b %h z=%b exp v=1 i=1 0 z=1", vld, ill, res, zero); end
    drive(2'b01, 10'h201, 32'd7, 32'd1);
    @(negedge clk);
    n_vec++; if (vld !== 1'b1 || ill !== 1'b1 || res !== 32'd0 || zero !== 1'b1) begin n_err++; $display("FAIL ill_slli got v=%b i=%b %h z=%b exp v=1 i=1 0 z=1", vld, ill, res, zero); end
    drive(2'b10, 10'h3FF, 32'd2, 32'd3);
    @(negedge clk);
    n_vec++; if (vld !== 1'b1 || ill !== 1'b0 || res !== 32'd5 || zero !== 1'b0) begin n_err++; $display("FAIL ill_clear got v=%b i=%b %h z=%b exp v=1 i=0 5 z=0", vld, ill, res, zero); end
    valid = 1'b0;
    @(negedge clk);
    n_vec++; if (vld !== 1'b0 || res !== 32'd5) begin n_err++; $display("FAIL ill_hold got v=%b %h exp v=0 5", vld, res); end
  endtask

  task automatic test_misc;
    logic [1:0]  t_op [6];
    logic [9:0]  t_f  [6];
    logic [31:0] t_a  [6];
    logic [31:0] t_b  [6];
    logic [31:0] t_e  [6];
    t_op[0] = 2'b00; t_f[0] = 10'h002; t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'd1;          t_e[0] = 32'd1;
    t_op[1] = 2'b00; t_f[1] = 10'h005; t_a[1] = 32'h0000_A5A5; t_b[1] = 32'd32;         t_e[1] = 32'h0000_A5A5;
    t_op[2] = 2'b01; t_f[2] = 10'h105; t_a[2] = 32'h8000_0000; t_b[2] = 32'd31;         t_e[2] = 32'hFFFF_FFFF;
    t_op[3] = 2'b11; t_f[3] = 10'h1FF; t_a[3] = 32'd7;         t_b[3] = 32'd7;          t_e[3] = 32'd0;
    t_op[4] = 2'b01; t_f[4] = 10'h004; t_a[4] = 32'hFF00_FF00; t_b[4] = 32'h0F0F_0F0F; t_e[4] = 32'hF00F_F00F;
    t_op[5] = 2'b01; t_f[5] = 10'h001; t_a[5] = 32'd1;         t_b[5] = 32'd31;         t_e[5] = 32'h8000_0000;
    @(negedge clk); drive(t_op[0], t_f[0], t_a[0], t_b[0]);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (vld !== 1'b1 || res !== t_e[i-1] || zero !== (t_e[i-1] == 32'd0) || ill !== 1'b0) begin
        n_err++; $display("FAIL misc_%0d got v=%b %h z=%b i=%b exp %h", i-1, vld, res, zero, ill, t_e[i-1]);
      end
      if (i < 6) drive(t_op[i], t_f[i], t_a[i], t_b[i]);
      else valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_mul;
    int pulses;
    pulses = 0;
    @(negedge clk); drive(2'b00, 10'h008, 32'hFFFF_FFFF, 32'd3);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (vld !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || res !== 32'd0 || zero !== 1'b0 || ill !== 1'b0) begin
      n_err++; $display("FAIL rstmul_state got v=%b r=%b b=%b %h z=%b i=%b exp v=0 r=1 b=0 0 z=0 i=0", vld, ready, busy, res, zero, ill);
    end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (vld === 1'b1) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL rstmul_no_valid got %0d exp 0", pulses); end
    drive(2'b01, 10'h000, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    n_vec++; if (vld !== 1'b1 || res !== 32'd0 || zero !== 1'b1) begin n_err++; $display("FAIL rstmul_addi got v=%b %h z=%b exp v=1 0 z=1", vld, res, zero); end
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    test_mul(32'd5, 32'd0, 32'd0);
    test_illegal();
    test_misc();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised successor to the single-cycle ALU control decode: it decodes funct/ALUOp and also executes the operation.
- Supports XLEN-wide operands, the full RV32I/M-subset op table, and an iterative multi-cycle multiplier.
- Uses a valid/ready input handshake and a one-cycle valid_o pulse on output.
- Sits in the EX stage between ID/EX operands and the EX/MEM register; the pipeline stalls on ready_o.

Parameters:
XLEN, 32, operand/result width; must be a power of two, 8..64
MUL_BITS, 1, multiplier bits retired per cycle; must divide XLEN, 1..XLEN

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
valid_i  in  1  operation request
ready_o  out  1  block can accept an operation this cycle
funct_i  in  10  {funct7, funct3}; funct7 = [9:3], funct3 = [2:0]
ALUOp_i  in  2  00 R-type, 01 I-type, 10 address add, 11 branch subtract
src1_i  in  XLEN  operand A
src2_i  in  XLEN  operand B (immediate already muxed in)
result_o  out  XLEN  registered result
zero_o  out  1  registered (result_o == 0)
valid_o  out  1  one-cycle pulse; result_o/zero_o/illegal_o valid
illegal_o  out  1  decoded combination unsupported; result_o forced 0
busy_o  out  1  multiply in progress (= ~ready_o)

Behaviour:
- Reset: state IDLE, result_o=0, zero_o=0, valid_o=0, illegal_o=0, ready_o=1, multiplier registers cleared.
- Reset mid-multiply aborts the operation; no valid_o is produced for it.
- Accept: valid_i && ready_o at a rising edge latches decode and operands. valid_i while ready_o=0 is ignored; operands are not sampled.
- Decode, ALUOp 00, funct3:
  - 111 and; 110 or; 100 xor; 001 sll; 010 slt; 011 sltu
  - 101: srl if funct7=0000000, sra if funct7=0100000
  - 000: add if funct7=0000000, sub if funct7=0100000, mul if funct7=0000001
  - Any other funct7 is illegal.
- Decode, ALUOp 01, funct3:
  - 000 addi; 111 andi; 110 ori; 100 xori; 010 slti; 011 sltiu
  - 001 slli, legal only with funct7=0000000
  - 101: srli if funct7=0000000, srai if funct7=0100000; any other funct7 is illegal.
- Decode, ALUOp 10: add, funct ignored.
- Decode, ALUOp 11: sub, funct ignored; zero_o is the branch-equal flag.
- Decode is fully specified with a default; no latches.
- Arithmetic rules:
  - Shift amount = src2_i[log2(XLEN)-1:0].
  - sra is arithmetic; slt is signed; sltu is unsigned; slt/sltu result is zero-extended 0/1.
  - add/sub wrap modulo 2^XLEN.
  - mul returns the low XLEN bits of the product; signedness is irrelevant for the low half.
- States:
  - IDLE: ready_o=1, valid_o=0. Accept of a non-mul op → DONE with registered result. Accept of mul → MUL with count = XLEN/MUL_BITS.
  - MUL: ready_o=0, busy_o=1. Each cycle adds src1 shifted by the processed-bit position × next MUL_BITS of src2 into the accumulator and decrements count. When count reaches 1 → DONE with the final accumulator in result_o.
  - DONE: valid_o=1 for exactly this cycle, ready_o=1. An accept in DONE goes straight to DONE/MUL (back-to-back); otherwise → IDLE.
- Latency (accept edge = cycle 0):
  - Non-mul: valid_o in cycle 1, throughput 1/cycle.
  - mul: valid_o in cycle XLEN/MUL_BITS + 1.
- result_o/zero_o/illegal_o hold their value after the valid_o pulse until the next completion.
- Illegal: completes like a single-cycle op with illegal_o=1, result_o=0, zero_o=1.
- Edge cases:
  - mul with src2=0 still takes the full iteration count.
  - Shift by 0 returns src1.
  - sub of equal operands gives zero_o=1.

Test Plan:
1. Reset held 2 cycles mid-stream → all outputs 0, ready_o=1; deassert, R-type add 5+7 (funct 0x000) → result_o=12, valid_o exactly 1 cycle after accept.
2. Back-to-back single-cycle ops: sub 3−3 (funct 0x100), sra 0x80000000>>4 (funct 0x105), sltu 1<0xFFFFFFFF (funct 0x003), one accepted per cycle → 0 (zero_o=1), 0xF8000000, 1, on three consecutive valid_o pulses.
3. mul 0xFFFFFFFF×3 (funct 0x008, XLEN=32, MUL_BITS=1) → ready_o=0 for 32 cycles; valid_o at cycle 33 with result 0xFFFFFFFD; valid_i asserted during busy is ignored.
4. Repeat scenario 3 with MUL_BITS=4 and 32 → valid_o at cycles 9 and 2; same result.
5. Illegal decodes: ALUOp 00 funct 0x009; ALUOp 01 funct 0x201 (slli, funct7≠0) → illegal_o=1, result_o=0, zero_o=1; next legal op clears illegal_o.
6. Reset asserted at cycle 10 of a mul → no valid_o for it; a new addi 0xFFFFFFFF+1 (ALUOp 01, funct3 000) after reset → result_o=0, zero_o=1.
